trig_lane_edge_counter: RTL

- Consumes the single-ended outputs of the 4-lane differential input buffer stage. Those outputs are asynchronous trigger/discriminator lines.
- Per lane: synchronizes into the system clock, detects rising edges, applies a programmable dead-time, and counts accepted edges.
- Counts are exported through a snapshot/acknowledge handshake to the housekeeping readout.
- Also produces per-lane single-cycle edge pulses for downstream trigger logic.

---
 rtl/trig_in_pkg.sv | 10 +
 rtl/trig_lane_edge_unit.sv | 47 ++++
 rtl/trig_lane_edge_counter.sv | 61 ++++++
 3 files changed

// File: rtl/trig_in_pkg.sv
// trig_in_pkg: shared defaults and snapshot indexing helper for the trigger lane edge counter.
package trig_in_pkg;
  localparam int NLANES_DEF      = 4;
  localparam int CNT_W_DEF       = 16;
  localparam int HOLD_W_DEF      = 8;
  localparam int SYNC_STAGES_MIN = 2;
  function automatic int lane_lsb(input int lane, input int width);
    return lane * width;
  endfunction
endpackage

// File: rtl/trig_lane_edge_unit.sv
// trig_lane_edge_unit: one lane of sync, rising-edge detect, dead-time, saturating count.
module trig_lane_edge_unit
  import trig_in_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_MIN,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int HOLD_W      = HOLD_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_lane,
  input  logic              i_enable,
  input  logic [HOLD_W-1:0] i_holdoff,
  input  logic              clear_i,
  output logic              o_edge,
  output logic [CNT_W-1:0]  o_cnt_nxt,
  output logic              o_sat_nxt
);
  localparam int SS = SYNC_STAGES < SYNC_STAGES_MIN ? SYNC_STAGES_MIN : SYNC_STAGES;
  logic [SS-1:0]     r_sync;
  logic              r_hist, r_edge, r_sat;
  logic [HOLD_W-1:0] r_timer;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_acc, w_max;
  assign w_acc     = r_sync[SS-1] & ~r_hist & i_enable & (r_timer == '0);
  assign w_max     = &r_cnt;
  assign o_cnt_nxt = r_cnt + CNT_W'(w_acc & ~w_max);
  assign o_sat_nxt = r_sat | (w_acc & w_max);
  assign o_edge    = r_edge;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync  <= '0;
      r_hist  <= 1'b0;
      r_edge  <= 1'b0;
      r_timer <= '0;
      r_cnt   <= '0;
      r_sat   <= 1'b0;
    end else begin
      r_sync  <= {r_sync[SS-2:0], i_lane};
      r_hist  <= r_sync[SS-1];
      r_edge  <= w_acc;
      r_timer <= w_acc ? i_holdoff : (r_timer != '0 ? r_timer - HOLD_W'(1) : r_timer);
      r_cnt   <= clear_i ? '0 : o_cnt_nxt;
      r_sat   <= clear_i ? 1'b0 : o_sat_nxt;
    end
  end
endmodule

// File: rtl/trig_lane_edge_counter.sv
// trig_lane_edge_counter: per-lane edge counting with snapshot/acknowledge export.
module trig_lane_edge_counter
  import trig_in_pkg::*;
#(
  parameter int NLANES      = NLANES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_MIN,
  parameter int CNT_W       = CNT_W_DEF,
  parameter int HOLD_W      = HOLD_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NLANES-1:0]       lane_in,
  input  logic                    enable,
  input  logic [HOLD_W-1:0]       holdoff,
  input  logic                    snap_req,
  input  logic                    snap_ack,
  output logic [NLANES-1:0]       edge_o,
  output logic                    snap_valid,
  output logic [NLANES*CNT_W-1:0] snap_cnt,
  output logic [NLANES-1:0]       snap_sat,
  output logic                    snap_overrun
);
  logic [NLANES*CNT_W-1:0] w_cnt_nxt, r_cnt;
  logic [NLANES-1:0]       w_sat_nxt, r_sat;
  logic                    r_valid, r_overrun;
  for (genvar i = 0; i < NLANES; i++) begin : g_lane
    trig_lane_edge_unit #(
      .SYNC_STAGES(SYNC_STAGES),
      .CNT_W      (CNT_W),
      .HOLD_W     (HOLD_W)
    ) u_unit (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_lane   (lane_in[i]),
      .i_enable (enable),
      .i_holdoff(holdoff),
      .clear_i  (snap_req),
      .o_edge   (edge_o[i]),
      .o_cnt_nxt(w_cnt_nxt[lane_lsb(i, CNT_W) +: CNT_W]),
      .o_sat_nxt(w_sat_nxt[i])
    );
  end
  // Snapshot captures next-state counts so an edge accepted alongside snap_req is included.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_sat     <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_cnt     <= snap_req ? w_cnt_nxt : r_cnt;
      r_sat     <= snap_req ? w_sat_nxt : r_sat;
      r_valid   <= snap_req | (r_valid & ~snap_ack);
      r_overrun <= (snap_req & r_valid & ~snap_ack) | (r_overrun & ~(r_valid & snap_ack));
    end
  end
  assign snap_cnt     = r_cnt;
  assign snap_sat     = r_sat;
  assign snap_valid   = r_valid;
  assign snap_overrun = r_overrun;
endmodule
